// File: rtl/byte_striping_2lane.sv
// Stripes consecutive valid words alternately onto two lanes, each buffered by a
// small show-ahead FIFO that its downstream serializer drains via a pop handshake.
module byte_striping_2lane #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              pop_0,
  input  logic              pop_1,
  output logic [DATA_W-1:0] data_lane_0,
  output logic              valid_lane_0,
  output logic [DATA_W-1:0] data_lane_1,
  output logic              valid_lane_1,
  output logic              full_0,
  output logic              full_1,
  output logic              overflow,
  output logic              lane_sel
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem    [2][FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr [2];
  logic [ADDR_W-1:0] rd_ptr [2];
  logic [ADDR_W:0]   count  [2];

  logic [1:0] push;
  logic [1:0] pop_req;
  logic [1:0] pop_ok;
  logic [1:0] accept;
  logic [1:0] drop;

  // A full lane still accepts a push when the same cycle pops it, since a slot frees up.
  always_comb begin
    push    = {valid_in & lane_sel, valid_in & ~lane_sel};
    pop_req = {pop_1, pop_0};
    pop_ok  = '0;
    accept  = '0;
    drop    = '0;
    for (int i = 0; i < 2; i++) begin
      pop_ok[i] = pop_req[i] && (count[i] != '0);
      accept[i] = push[i] && ((count[i] != FULL_CNT) || pop_ok[i]);
      drop[i]   = push[i] && !accept[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      lane_sel <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      // Idle cycles realign striping so every burst begins on lane 0.
      lane_sel <= valid_in ? ~lane_sel : 1'b0;
      if (|drop) overflow <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (accept[i]) wr_ptr[i] <= wr_ptr[i] + ADDR_W'(1);
        if (pop_ok[i]) rd_ptr[i] <= rd_ptr[i] + ADDR_W'(1);
        case ({accept[i], pop_ok[i]})
          2'b10:   count[i] <= count[i] + (ADDR_W + 1)'(1);
          2'b01:   count[i] <= count[i] - (ADDR_W + 1)'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; empty lanes mask it via count, so clearing
  // it would only cost reset fan-out and block RAM inference.
  always_ff @(posedge clk_2f) begin
    for (int i = 0; i < 2; i++) begin
      if (reset && accept[i]) mem[i][wr_ptr[i]] <= data_in;
    end
  end

  assign valid_lane_0 = (count[0] != '0);
  assign valid_lane_1 = (count[1] != '0);
  assign data_lane_0  = valid_lane_0 ? mem[0][rd_ptr[0]] : '0;
  assign data_lane_1  = valid_lane_1 ? mem[1][rd_ptr[1]] : '0;
  assign full_0       = (count[0] == FULL_CNT);
  assign full_1       = (count[1] == FULL_CNT);

endmodule

// File: tb/tb_byte_striping_2lane.sv
// Directed self-checking bench for byte_striping_2lane: reset, striping, realignment,
// full/overflow, push-while-full-with-pop, empty pops and mid-stream reset.
module tb_byte_striping_2lane;

  logic        clk_2f = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        pop_0;
  logic        pop_1;
  logic [31:0] data_lane_0;
  logic        valid_lane_0;
  logic [31:0] data_lane_1;
  logic        valid_lane_1;
  logic        full_0;
  logic        full_1;
  logic        overflow;
  logic        lane_sel;

  int n_checks = 0;
  int n_fail   = 0;

  byte_striping_2lane #(.DATA_W(32), .FIFO_DEPTH(4), .ADDR_W(2)) dut (
    .clk_2f      (clk_2f),
    .reset       (reset),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .pop_0       (pop_0),
    .pop_1       (pop_1),
    .data_lane_0 (data_lane_0),
    .valid_lane_0(valid_lane_0),
    .data_lane_1 (data_lane_1),
    .valid_lane_1(valid_lane_1),
    .full_0      (full_0),
    .full_1      (full_1),
    .overflow    (overflow),
    .lane_sel    (lane_sel)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Apply current inputs across one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    valid_in = 1'b1;
    data_in  = w;
    step();
  endtask

  task automatic idle();
    valid_in = 1'b0;
    data_in  = '0;
    pop_0    = 1'b0;
    pop_1    = 1'b0;
    step();
  endtask

  task automatic pop_lanes(input logic p0, input logic p1);
    valid_in = 1'b0;
    pop_0    = p0;
    pop_1    = p1;
    step();
    pop_0    = 1'b0;
    pop_1    = 1'b0;
  endtask

  initial begin
    pop_0 = 1'b0;
    pop_1 = 1'b0;

    // 1: reset held two cycles while an all-ones word is offered
    reset    = 1'b0;
    valid_in = 1'b1;
    data_in  = 32'hFFFF_FFFF;
    step();
    step();
    check("rst_valid0", 32'(valid_lane_0), 32'd0);
    check("rst_valid1", 32'(valid_lane_1), 32'd0);
    check("rst_data0",  data_lane_0, 32'd0);
    check("rst_data1",  data_lane_1, 32'd0);
    check("rst_full0",  32'(full_0), 32'd0);
    check("rst_full1",  32'(full_1), 32'd0);
    check("rst_ovf",    32'(overflow), 32'd0);
    check("rst_sel",    32'(lane_sel), 32'd0);
    reset = 1'b1;
    idle();

    // 2: four-word burst, no pops, then one pop per lane
    push_word(32'hA1);
    check("b2_sel_after_1", 32'(lane_sel), 32'd1);
    check("b2_first_latency", data_lane_0, 32'hA1);
    push_word(32'hA2);
    push_word(32'hA3);
    push_word(32'hA4);
    idle();
    check("b2_head0", data_lane_0, 32'hA1);
    check("b2_head1", data_lane_1, 32'hA2);
    check("b2_sel_idle", 32'(lane_sel), 32'd0);
    check("b2_full0", 32'(full_0), 32'd0);
    pop_lanes(1'b1, 1'b1);
    check("b2_pop_head0", data_lane_0, 32'hA3);
    check("b2_pop_head1", data_lane_1, 32'hA4);
    pop_lanes(1'b1, 1'b1);
    check("b2_drain_v0", 32'(valid_lane_0), 32'd0);
    check("b2_drain_v1", 32'(valid_lane_1), 32'd0);
    check("b2_drain_d0", data_lane_0, 32'd0);

    // 3: A1, gap, B1, B2 -> B1 realigns to lane 0
    push_word(32'h31);
    idle();
    push_word(32'hB1);
    push_word(32'hB2);
    idle();
    check("b3_head0", data_lane_0, 32'h31);
    check("b3_head1", data_lane_1, 32'hB2);
    pop_lanes(1'b1, 1'b0);
    check("b3_second0", data_lane_0, 32'hB1);
    pop_lanes(1'b1, 1'b1);
    check("b3_empty0", 32'(valid_lane_0), 32'd0);
    check("b3_empty1", 32'(valid_lane_1), 32'd0);
    check("b3_no_ovf", 32'(overflow), 32'd0);

    // 4: ten-word burst, no pops -> both lanes full, words 9 and 10 dropped
    for (int k = 1; k <= 8; k++) push_word(32'h100 + 32'(k));
    check("b4_full0_at8", 32'(full_0), 32'd1);
    check("b4_no_ovf_at8", 32'(overflow), 32'd0);
    push_word(32'h109);
    check("b4_ovf_at9", 32'(overflow), 32'd1);
    push_word(32'h10A);
    idle();
    check("b4_full0", 32'(full_0), 32'd1);
    check("b4_full1", 32'(full_1), 32'd1);
    check("b4_head0", data_lane_0, 32'h101);
    check("b4_head1", data_lane_1, 32'h102);
    check("b4_sel", 32'(lane_sel), 32'd0);

    // 5: lane 0 full, push with a same-cycle pop -> accepted as new tail
    valid_in = 1'b1;
    data_in  = 32'h5A;
    pop_0    = 1'b1;
    step();
    pop_0 = 1'b0;
    idle();
    check("b5_full0", 32'(full_0), 32'd1);
    check("b5_head0", data_lane_0, 32'h103);
    check("b5_ovf_sticky", 32'(overflow), 32'd1);
    begin
      logic [31:0] exp0 [4];
      exp0 = '{32'h103, 32'h105, 32'h107, 32'h5A};
      for (int k = 0; k < 4; k++) begin
        check($sformatf("b5_order0_%0d", k), data_lane_0, exp0[k]);
        pop_lanes(1'b1, 1'b0);
        check($sformatf("b5_full0_after_pop%0d", k), 32'(full_0), 32'd0);
      end
    end
    check("b5_drained0", 32'(valid_lane_0), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b5_order1_%0d", k), data_lane_1, 32'h102 + 32'(2 * k));
      pop_lanes(1'b0, 1'b1);
    end
    check("b5_drained1", 32'(valid_lane_1), 32'd0);

    // 6: pops on an empty lane are ignored, then push C1
    for (int k = 0; k < 3; k++) pop_lanes(1'b1, 1'b0);
    check("b6_empty_pop_v0", 32'(valid_lane_0), 32'd0);
    push_word(32'hC1);
    idle();
    check("b6_c1_valid", 32'(valid_lane_0), 32'd1);
    check("b6_c1_data", data_lane_0, 32'hC1);
    push_word(32'hD1);
    push_word(32'hD2);
    push_word(32'hD3);
    valid_in = 1'b0;
    check("b6_pre_rst_v1", 32'(valid_lane_1), 32'd1);
    check("b6_pre_rst_ovf", 32'(overflow), 32'd1);
    reset = 1'b0;
    step();
    check("b6_rst_v0", 32'(valid_lane_0), 32'd0);
    check("b6_rst_v1", 32'(valid_lane_1), 32'd0);
    check("b6_rst_ovf", 32'(overflow), 32'd0);
    check("b6_rst_d0", data_lane_0, 32'd0);
    reset = 1'b1;
    idle();
    push_word(32'hE1);
    idle();
    check("b6_post_rst_head", data_lane_0, 32'hE1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
